dmem_responder: RTL and testbench

Memory-side responder for the CPU data-memory request channel that the memory stage drives. Accepts one load or store per cycle, performs RV32I byte/half/word lane steering from `funct3`, and returns read data or a store acknowledge one cycle later. Also flags misaligned, out-of-range and illegal-width accesses. A boot-loader write port, which has priority over the CPU, preloads the word array.

---
 rtl/riscv_defs_pkg.sv | 27 ++
 rtl/dmem_load_align.sv | 33 +++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared RV32I data-memory definitions: widths, load/store funct3 codes,
// error causes and the responder FSM states.
package riscv_defs;

   localparam int NB_WORD = 32;
   localparam int NB_ADDR = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2,
      ERR_FUNCT3   = 2'd3
   } dmem_err_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RESP = 2'd1,
      ST_LOAD = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half from a raw memory word and applies
// RV32I sign or zero extension according to the load funct3.
module dmem_load_align
   import riscv_defs::*;
(
   input  logic [NB_WORD-1:0] word,
   input  logic [1:0]         addr_lo,
   input  logic [2:0]         funct3,
   output logic [NB_WORD-1:0] data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      case (addr_lo)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      sel_half = addr_lo[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   data = {24'd0, sel_byte};
         F3_H:    data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   data = {16'd0, sel_half};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: one load/store per cycle with lane steering,
// registered response one cycle later, and a priority boot-loader write port.
module dmem_responder
   import riscv_defs::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
)(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_req_valid,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [2:0]  i_req_funct3,
   output logic        o_req_ready,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [1:0]  o_rsp_err_cause,
   input  logic        i_ld_valid,
   input  logic [31:0] i_ld_addr,
   input  logic [31:0] i_ld_data
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

   logic [31:0]   mem [DEPTH_WORDS];
   logic          accept;
   logic [31:0]   req_off, ld_off;
   logic [AW-1:0] req_idx, ld_idx;
   logic          req_in_range, ld_in_range;
   logic          f3_legal, misalign;
   dmem_err_e     err_cause;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic [31:0]   load_data;
   dmem_state_e   state;

   assign o_req_ready = !i_ld_valid;
   assign accept      = i_req_valid && !i_ld_valid;

   // An address below BASE_ADDR wraps to a huge offset, so one compare covers both ends.
   assign req_off      = i_req_addr - BASE_ADDR;
   assign req_in_range = req_off < SPAN;
   assign req_idx      = req_off[AW+1:2];
   assign ld_off       = i_ld_addr - BASE_ADDR;
   assign ld_in_range  = ld_off < SPAN;
   assign ld_idx       = ld_off[AW+1:2];

   always_comb begin
      f3_legal  = 1'b0;
      misalign  = 1'b0;
      be        = 4'b0000;
      wdata_rep = i_req_wdata;
      case (i_req_funct3)
         F3_B, F3_BU: begin
            f3_legal  = !i_req_we || (i_req_funct3 == F3_B);
            be        = 4'b0001 << i_req_addr[1:0];
            wdata_rep = {4{i_req_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            f3_legal  = !i_req_we || (i_req_funct3 == F3_H);
            misalign  = i_req_addr[0];
            be        = 4'b0011 << i_req_addr[1:0];
            wdata_rep = {2{i_req_wdata[15:0]}};
         end
         F3_W: begin
            f3_legal = 1'b1;
            misalign = (i_req_addr[1:0] != 2'd0);
            be       = 4'hF;
         end
         default: ;
      endcase

      if (!f3_legal)          err_cause = ERR_FUNCT3;
      else if (misalign)      err_cause = ERR_MISALIGN;
      else if (!req_in_range) err_cause = ERR_RANGE;
      else                    err_cause = ERR_NONE;
   end

   dmem_load_align u_align (
      .word    (mem[req_idx]),
      .addr_lo (i_req_addr[1:0]),
      .funct3  (i_req_funct3),
      .data    (load_data)
   );

   // The array has no reset so preloaded contents survive a CPU reset.
   always_ff @(posedge i_clock) begin
      if (i_ld_valid) begin
         if (ld_in_range)
            mem[ld_idx] <= i_ld_data;
      end else if (accept && i_req_we && (err_cause == ERR_NONE)) begin
         for (int b = 0; b < 4; b++)
            if (be[b])
               mem[req_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state           <= ST_IDLE;
         o_rsp_valid     <= 1'b0;
         o_rsp_rdata     <= 32'd0;
         o_rsp_err       <= 1'b0;
         o_rsp_err_cause <= 2'd0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (i_ld_valid)  state <= ST_LOAD;
               else if (accept) state <= ST_RESP;
               else             state <= ST_IDLE;
            end
            default: begin
               if (i_ld_valid)  state <= ST_LOAD;
               else if (accept) state <= ST_RESP;
               else             state <= ST_IDLE;
            end
         endcase

         o_rsp_valid     <= accept;
         o_rsp_rdata     <= (accept && !i_req_we && (err_cause == ERR_NONE)) ? load_data : 32'd0;
         o_rsp_err       <= accept && (err_cause != ERR_NONE);
         o_rsp_err_cause <= accept ? err_cause : ERR_NONE;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed memory model.
module tb_dmem_responder;
   import riscv_defs::*;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 1024;
   localparam int          NBYTE = DEPTH * 4;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        i_req_we = 1'b0;
   logic [31:0] i_req_addr = '0;
   logic [31:0] i_req_wdata = '0;
   logic [2:0]  i_req_funct3 = '0;
   logic        o_req_ready;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic [1:0]  o_rsp_err_cause;
   logic        i_ld_valid = 1'b0;
   logic [31:0] i_ld_addr = '0;
   logic [31:0] i_ld_data = '0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  mb [NBYTE];
   logic [31:0] last_rdata;
   logic        last_valid;
   logic [1:0]  last_cause;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_req_valid     (i_req_valid),
      .i_req_we        (i_req_we),
      .i_req_addr      (i_req_addr),
      .i_req_wdata     (i_req_wdata),
      .i_req_funct3    (i_req_funct3),
      .o_req_ready     (o_req_ready),
      .o_rsp_valid     (o_rsp_valid),
      .o_rsp_rdata     (o_rsp_rdata),
      .o_rsp_err       (o_rsp_err),
      .o_rsp_err_cause (o_rsp_err_cause),
      .i_ld_valid      (i_ld_valid),
      .i_ld_addr       (i_ld_addr),
      .i_ld_data       (i_ld_data)
   );

   always #5 i_clock = ~i_clock;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive a CPU request and/or loader write, predict from the
   // model, then check the response one edge later. Called just after a rising edge.
   task automatic step(input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input logic ldv, input logic [31:0] ldaddr, input logic [31:0] lddata);
      logic [31:0] off, v32, ld_off;
      int          sz;
      logic        ill, mis, oor, acc;
      logic [1:0]  cause;
      logic [31:0] exp_rdata;

      i_req_valid = v;  i_req_we = we;  i_req_addr = addr;
      i_req_wdata = wd; i_req_funct3 = f3;
      i_ld_valid = ldv; i_ld_addr = ldaddr; i_ld_data = lddata;
      #1;
      check_vec("ready", {31'd0, o_req_ready}, {31'd0, !ldv});

      acc       = v && !ldv;
      off       = addr - BASE;
      ill       = we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      sz        = 1 << f3[1:0];
      mis       = (addr % sz) != 0;
      oor       = off >= NBYTE;
      cause     = ill ? 2'd3 : mis ? 2'd1 : oor ? 2'd2 : 2'd0;
      exp_rdata = 32'd0;

      if (ldv) begin
         ld_off = ldaddr - BASE;
         if (ld_off < NBYTE)
            for (int i = 0; i < 4; i++) mb[(ld_off & ~32'd3) + i] = lddata[8*i +: 8];
      end else if (acc && cause == 2'd0) begin
         if (we) begin
            for (int i = 0; i < sz; i++) mb[off + i] = wd[8*i +: 8];
         end else begin
            v32 = 32'd0;
            for (int i = 0; i < sz; i++) v32 = v32 | ({24'd0, mb[off + i]} << (8 * i));
            if (f3 == 3'd0 && v32[7])  v32 = v32 | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v32[15]) v32 = v32 | 32'hFFFF_0000;
            exp_rdata = v32;
         end
      end

      @(posedge i_clock);
      #1;
      i_req_valid = 1'b0;
      i_ld_valid  = 1'b0;
      last_rdata  = o_rsp_rdata;
      last_valid  = o_rsp_valid;
      last_cause  = o_rsp_err_cause;
      check_vec("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, acc});
      if (acc) begin
         check_vec("rsp_rdata", o_rsp_rdata, exp_rdata);
         check_vec("rsp_err", {31'd0, o_rsp_err}, {31'd0, cause != 2'd0});
         check_vec("rsp_cause", {30'd0, o_rsp_err_cause}, {30'd0, cause});
      end
   endtask

   task automatic cpu(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
      step(1'b1, we, addr, wd, f3, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic loader(input logic [31:0] addr, input logic [31:0] data);
      step(1'b0, 1'b0, 32'd0, 32'd0, F3_W, 1'b1, addr, data);
   endtask

   initial begin
      logic [31:0] addr, ldaddr;
      logic [2:0]  f3;
      int          r;

      for (int i = 0; i < NBYTE; i++) mb[i] = 8'd0;

      repeat (2) @(posedge i_clock);
      #1;
      check_vec("reset_valid", {31'd0, o_rsp_valid}, 32'd0);
      check_vec("reset_rdata", o_rsp_rdata, 32'd0);
      check_vec("reset_err", {31'd0, o_rsp_err}, 32'd0);
      check_vec("reset_cause", {30'd0, o_rsp_err_cause}, 32'd0);
      check_vec("reset_ready", {31'd0, o_req_ready}, 32'd1);
      i_reset = 1'b0;

      for (int w = 0; w < 32; w++) loader(BASE + 32'(4 * w), $urandom);

      loader(32'h2000, 32'hDEAD_BEEF);
      cpu(1'b0, 32'h2000, 32'd0, F3_W);
      check_vec("lw_beef", last_rdata, 32'hDEAD_BEEF);
      cpu(1'b0, 32'h2003, 32'd0, F3_B);
      check_vec("lb_de", last_rdata, 32'hFFFF_FFDE);
      cpu(1'b0, 32'h2003, 32'd0, F3_BU);
      check_vec("lbu_de", last_rdata, 32'h0000_00DE);
      cpu(1'b0, 32'h2002, 32'd0, F3_H);
      check_vec("lh_dead", last_rdata, 32'hFFFF_DEAD);
      cpu(1'b0, 32'h2000, 32'd0, F3_HU);
      check_vec("lhu_beef", last_rdata, 32'h0000_BEEF);

      cpu(1'b1, 32'h2001, 32'h55, F3_B);
      check_vec("sb_valid", {31'd0, last_valid}, 32'd1);
      cpu(1'b0, 32'h2000, 32'd0, F3_W);
      check_vec("b2b_valid", {31'd0, last_valid}, 32'd1);
      check_vec("b2b_rdata", last_rdata, 32'hDEAD_55EF);

      cpu(1'b1, 32'h2002, 32'hFFFF_FFFF, F3_W);
      check_vec("sw_mis_cause", {30'd0, last_cause}, 32'd1);
      cpu(1'b0, 32'h2000, 32'd0, F3_W);
      check_vec("sw_mis_nowrite", last_rdata, 32'hDEAD_55EF);
      cpu(1'b0, 32'h1FFC, 32'd0, F3_W);
      check_vec("lw_range_cause", {30'd0, last_cause}, 32'd2);
      cpu(1'b0, BASE + 32'(NBYTE), 32'd0, F3_W);
      check_vec("lw_top_cause", {30'd0, last_cause}, 32'd2);
      cpu(1'b0, 32'h2000, 32'd0, 3'b011);
      check_vec("ld_f3_cause", {30'd0, last_cause}, 32'd3);
      cpu(1'b1, 32'h2000, 32'd0, 3'b100);
      check_vec("st_f3_cause", {30'd0, last_cause}, 32'd3);

      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b0, 32'h2000, 32'd0, F3_W, 1'b1, 32'h2008 + 32'(4 * k), $urandom);
      cpu(1'b0, 32'h2000, 32'd0, F3_W);
      check_vec("held_accept", {31'd0, last_valid}, 32'd1);

      cpu(1'b1, 32'h2004, 32'h1234_5678, F3_W);
      cpu(1'b0, 32'h2000, 32'd0, F3_W);
      #2;
      i_reset = 1'b1;
      #1;
      check_vec("arst_valid", {31'd0, o_rsp_valid}, 32'd0);
      check_vec("arst_rdata", o_rsp_rdata, 32'd0);
      check_vec("arst_err", {31'd0, o_rsp_err}, 32'd0);
      check_vec("arst_cause", {30'd0, o_rsp_err_cause}, 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0;
      @(posedge i_clock);
      #1;
      cpu(1'b0, 32'h2004, 32'd0, F3_W);
      check_vec("survive_reset", last_rdata, 32'h1234_5678);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 15);
         if (r == 0)      addr = BASE - 32'($urandom_range(1, 16));
         else if (r == 1) addr = BASE + 32'(NBYTE) + 32'($urandom_range(0, 15));
         else             addr = BASE + 32'($urandom_range(0, 127));
         r = $urandom_range(0, 7);
         case (r)
            0, 1:    f3 = F3_W;
            2:       f3 = F3_H;
            3:       f3 = F3_HU;
            4:       f3 = F3_B;
            5:       f3 = F3_BU;
            default: f3 = 3'($urandom_range(0, 7));
         endcase
         ldaddr = ($urandom_range(0, 7) == 0) ? BASE - 32'd4 : BASE + 32'($urandom_range(0, 127));
         step($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), addr, $urandom, f3,
              $urandom_range(0, 9) == 0, ldaddr, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
